bcd_timer_ctrl: RTL and testbench
=================================

# bcd_timer_ctrl

Sequencing controller for the three-digit cascaded BCD counter (ones/tens/hundreds, 000–999). Runs a prescaler that issues single-cycle count enables and accepts start/stop/clear commands. Compares the live BCD count against a programmable BCD target and halts the counter when it is reached. Sits between the user control logic and the counter's `enable`/`reset` pins, turning the free-running counter into a stopwatch/interval timer.

## Interface
- `PRESCALE`, 100: clk cycles per count increment; legal range 2..65535.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle command pulse; start or resume.
- `stop` in 1: one-cycle command pulse; pause.
- `clear` in 1: one-cycle command pulse; abort and zero the counter.
- `target_ones`, `target_tens`, `target_hundreds` in 4 each: BCD target; sampled on an accepted `start`.
- `cnt_ones`, `cnt_tens`, `cnt_hundreds` in 4 each: live digits from the counter.
- `cnt_en` out 1: drives counter `enable`; high for exactly one cycle per tick.
- `cnt_clr` out 1: drives counter `reset` (active-high); one-cycle pulse.
- `running` out 1: state == RUN.
- `paused` out 1: state == PAUSE.
- `expired` out 1: state == DONE (level).
- `expire_pulse` out 1: one cycle on entry to DONE.
- `err` out 1: one-cycle pulse when `start` is rejected because the target is non-BCD.

## Operation
- **Reset state.** `reset_n` low sets the state to IDLE, the prescaler to 0 and the target register to 000. All outputs read 0.
- **Command priority** in the same cycle: `clear` > `stop` > `start`.
- **States:** IDLE, RUN, PAUSE, DONE.
- **IDLE:**
  - `start` with every target digit ≤9: latch the target, zero the prescaler, go to RUN.
  - `start` with any target digit >9: stay in IDLE and pulse `err`.
- **RUN:**
  - The prescaler counts 0..PRESCALE-1 and wraps.
  - `cnt_en` = (prescaler == PRESCALE-1) & RUN & !match. It is combinational from registers.
  - `match` = the live count equals the latched target, compared combinationally.
  - When `match` is true, go to DONE on the next edge. `cnt_en` is suppressed in the matching cycle, so the counter never passes the target.
  - `stop`: go to PAUSE; the prescaler holds its value.
- **PAUSE:**
  - `cnt_en` = 0.
  - `start`: go to RUN and resume the prescaler from its held value. The target is not re-latched.
  - `stop`: ignored.
- **DONE:**
  - `cnt_en` = 0 and `expired` = 1.
  - `start`: pulse `cnt_clr`, re-latch the target, zero the prescaler, go to RUN.
  - `stop`: ignored.
- **`clear` in any state:** pulse `cnt_clr` for one cycle, zero the prescaler, go to IDLE.
- **Target below the count at start** (e.g. count 500, target 200): the counter runs through 999→000 and stops at 200. This is legal; there is no error.
- **Target equal to the count at start:** `match` is true in the first RUN cycle, so the block enters DONE one cycle later and no `cnt_en` is issued.

## Timing
- Accepted `start` at edge N: `running` = 1 after edge N.
- First `cnt_en` is high in cycle N+PRESCALE-1, and the counter increments at the following edge.
- Subsequent `cnt_en` pulses are exactly PRESCALE cycles apart.
- The counter reaches the target at edge M. `match` is true in the cycle after M. `expired` and `expire_pulse` rise after edge M+1.
- `cnt_clr` and `err` are registered pulses, high the cycle after the command.
- `PRESCALE` ≥ 2 guarantees that `match` is evaluated before the next `cnt_en`.
- Asserting `reset_n` mid-count immediately drops `cnt_en`. The counter's own contents are reset by its own reset, not by this block.

## Configuration
- `BCD_TIMER_LAP_EN` defined:
  - Adds port `lap` (in, 1).
  - Adds ports `lap_ones`, `lap_tens`, `lap_hundreds` (out, 4 each) and `lap_valid` (out, 1).
  - `lap` in RUN or PAUSE captures the live count on the next edge and pulses `lap_valid` for one cycle.
  - `lap` in IDLE or DONE is ignored.
  - Lap registers reset to 000 and are cleared by `clear`.
- Macro undefined: the lap ports and logic are absent; behaviour is otherwise identical.

## Structure
- Package `bcd_timer_pkg`:
  - state enum `bcd_timer_state_t` {IDLE, RUN, PAUSE, DONE};
  - `BCD_W` = 4;
  - `BCD_MAX` = 4'd9;
  - function `is_bcd3()` to validate a three-digit target.
- Sub-module `tick_gen`:
  - prescaler with `run`, `zero` and `hold` controls;
  - outputs the terminal-count flag `tick`;
  - parameterised by `PRESCALE`.
- The top level holds the FSM, target latch, comparator and lap registers.

## Test plan
- PRESCALE=4, target 012, `start` → `cnt_en` pulses every 4 cycles; exactly 12 pulses; counter stops at 012; single `expire_pulse`; `expired` holds.
- Target 0A5, `start` → `err` pulse; state stays IDLE; `cnt_en` never asserted.
- Run to count 007, `stop`, wait 50 cycles, `start` → no `cnt_en` while paused; the next `cnt_en` arrives after the remaining prescaler cycles; the count continues at 008.
- Count 998, target 001 → the count wraps 999→000→001, then DONE; `expired`=1.
- `clear` together with `stop` and `start` in the same cycle during RUN → `cnt_clr` pulse, IDLE, no `err`. Then `reset_n` low mid-RUN → all outputs 0 asynchronously.
- `BCD_TIMER_LAP_EN`: `lap` at count 045 → `lap_*` = 045 and `lap_valid` is a one-cycle pulse; `lap` in DONE produces no pulse.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD timer controller.
//   bcd_timer_state_t : controller state encoding (IDLE, RUN, PAUSE, DONE)
//   BCD_W             : width of one BCD digit
//   BCD_MAX           : largest legal BCD digit value
//   is_bcd3()         : true when all three digits of a target are legal BCD
package bcd_timer_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } bcd_timer_state_t;

  function automatic logic is_bcd3(input logic [BCD_W-1:0] hundreds,
                                   input logic [BCD_W-1:0] tens,
                                   input logic [BCD_W-1:0] ones);
    return (hundreds <= BCD_MAX) && (tens <= BCD_MAX) && (ones <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_tick_gen.sv
// Prescaler for the BCD timer controller.
// Counts 0..PRESCALE-1 while run is high and wraps; tick flags the terminal
// count (combinational from the count register).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   run          : advance the prescaler this cycle
//   zero         : force the prescaler to 0 (highest priority)
//   hold         : freeze the prescaler even if run is high
//   tick         : prescaler is at PRESCALE-1
// Parameter PRESCALE: cycles per tick, 2..65535.
module tick_gen #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic zero,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (zero) begin
      count <= '0;
    end else if (run && !hold) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Sequencing controller for a three-digit cascaded BCD counter (000-999).
// Issues single-cycle count enables from a prescaler, accepts start/stop/clear
// commands (clear > stop > start) and halts when the live count matches a
// latched BCD target.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   start, stop, clear           : one-cycle command pulses
//   target_ones/tens/hundreds    : BCD target, latched on an accepted start
//   cnt_ones/tens/hundreds       : live digits from the counter
//   cnt_en                       : counter enable, one cycle per tick
//   cnt_clr                      : counter reset pulse (registered)
//   running, paused, expired     : state == RUN / PAUSE / DONE
//   expire_pulse                 : one cycle on entry to DONE
//   err                          : start rejected because target is non-BCD
// Optional feature, macro BCD_TIMER_LAP_EN:
//   lap (in), lap_ones/tens/hundreds (out), lap_valid (out) - capture of the
//   live count while RUN or PAUSE.
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [BCD_W-1:0] target_ones,
  input  logic [BCD_W-1:0] target_tens,
  input  logic [BCD_W-1:0] target_hundreds,
  input  logic [BCD_W-1:0] cnt_ones,
  input  logic [BCD_W-1:0] cnt_tens,
  input  logic [BCD_W-1:0] cnt_hundreds,
`ifdef BCD_TIMER_LAP_EN
  input  logic             lap,
  output logic [BCD_W-1:0] lap_ones,
  output logic [BCD_W-1:0] lap_tens,
  output logic [BCD_W-1:0] lap_hundreds,
  output logic             lap_valid,
`endif
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             running,
  output logic             paused,
  output logic             expired,
  output logic             expire_pulse,
  output logic             err
);

  bcd_timer_state_t state, state_next;

  logic [3*BCD_W-1:0] target_q;
  logic               target_ok;
  logic               match;
  logic               tick;
  logic               latch_target;
  logic               pre_zero;
  logic               clr_req;
  logic               err_req;

  assign target_ok = is_bcd3(target_hundreds, target_tens, target_ones);
  assign match     = ({cnt_hundreds, cnt_tens, cnt_ones} == target_q);

  // Prescaler keeps advancing through the cycle in which stop is taken, so
  // the number of RUN cycles between ticks stays PRESCALE across a pause.
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (state == RUN),
    .zero   (pre_zero),
    .hold   (state == PAUSE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    latch_target = 1'b0;
    pre_zero     = 1'b0;
    clr_req      = 1'b0;
    err_req      = 1'b0;
    if (clear) begin
      state_next = IDLE;
      pre_zero   = 1'b1;
      clr_req    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (!stop && start) begin
            if (target_ok) begin
              latch_target = 1'b1;
              pre_zero     = 1'b1;
              state_next   = RUN;
            end else begin
              err_req = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_next = PAUSE;
          end else if (match) begin
            state_next = DONE;
          end
        end
        PAUSE: begin
          if (!stop && start) begin
            state_next = RUN;
          end
        end
        DONE: begin
          if (!stop && start) begin
            if (target_ok) begin
              clr_req      = 1'b1;
              latch_target = 1'b1;
              pre_zero     = 1'b1;
              state_next   = RUN;
            end else begin
              err_req = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q <= '0;
    end else if (latch_target) begin
      target_q <= {target_hundreds, target_tens, target_ones};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_clr      <= 1'b0;
      err          <= 1'b0;
      expire_pulse <= 1'b0;
    end else begin
      cnt_clr      <= clr_req;
      err          <= err_req;
      expire_pulse <= (state_next == DONE) && (state != DONE);
    end
  end

  // Enable is suppressed in the matching cycle so the counter never
  // steps past the target.
  assign cnt_en  = tick && (state == RUN) && !match;
  assign running = (state == RUN);
  assign paused  = (state == PAUSE);
  assign expired = (state == DONE);

`ifdef BCD_TIMER_LAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_ones     <= '0;
      lap_tens     <= '0;
      lap_hundreds <= '0;
      lap_valid    <= 1'b0;
    end else if (clear) begin
      lap_ones     <= '0;
      lap_tens     <= '0;
      lap_hundreds <= '0;
      lap_valid    <= 1'b0;
    end else if (lap && ((state == RUN) || (state == PAUSE))) begin
      lap_ones     <= cnt_ones;
      lap_tens     <= cnt_tens;
      lap_hundreds <= cnt_hundreds;
      lap_valid    <= 1'b1;
    end else begin
      lap_valid    <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench for bcd_timer_ctrl with PRESCALE=4. The bench models
// the cascaded BCD counter that the controller drives.
module tb_bcd_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, stop, clear;
  logic [3:0] target_ones, target_tens, target_hundreds;
  logic [3:0] cnt_ones, cnt_tens, cnt_hundreds;
  logic       cnt_en, cnt_clr, running, paused, expired, expire_pulse, err;
`ifdef BCD_TIMER_LAP_EN
  logic       lap;
  logic [3:0] lap_ones, lap_tens, lap_hundreds;
  logic       lap_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bcd_timer_ctrl #(
    .PRESCALE(4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .stop           (stop),
    .clear          (clear),
    .target_ones    (target_ones),
    .target_tens    (target_tens),
    .target_hundreds(target_hundreds),
    .cnt_ones       (cnt_ones),
    .cnt_tens       (cnt_tens),
    .cnt_hundreds   (cnt_hundreds),
`ifdef BCD_TIMER_LAP_EN
    .lap            (lap),
    .lap_ones       (lap_ones),
    .lap_tens       (lap_tens),
    .lap_hundreds   (lap_hundreds),
    .lap_valid      (lap_valid),
`endif
    .cnt_en         (cnt_en),
    .cnt_clr        (cnt_clr),
    .running        (running),
    .paused         (paused),
    .expired        (expired),
    .expire_pulse   (expire_pulse),
    .err            (err)
  );

  // Counter model: {hundreds, tens, ones}
  logic [11:0] cnt;
  logic        load_req;
  logic [11:0] load_val;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] o, t, h;
    o = v[3:0];
    t = v[7:4];
    h = v[11:8];
    if (o == 4'd9) begin
      o = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = (h == 4'd9) ? 4'd0 : h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      o = o + 4'd1;
    end
    return {h, t, o};
  endfunction

  always @(posedge clk) begin
    if (load_req)     cnt <= load_val;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_en)  cnt <= bcd_inc(cnt);
  end

  assign cnt_ones     = cnt[3:0];
  assign cnt_tens     = cnt[7:4];
  assign cnt_hundreds = cnt[11:8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cnt_load(input logic [11:0] v);
    load_val = v;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic set_target(input logic [11:0] v);
    target_hundreds = v[11:8];
    target_tens     = v[7:4];
    target_ones     = v[3:0];
  endtask

  task automatic cmd_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic cmd_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  // Observation window; offsets are cycles after the current sample point.
  int n_en, first_en, last_en, gap_err, n_exp, exp_at, n_err;

  task automatic watch(input int cycles);
    n_en = 0; first_en = -1; last_en = -1; gap_err = 0;
    n_exp = 0; exp_at = -1; n_err = 0;
    for (int k = 0; k < cycles; k++) begin
      if (cnt_en) begin
        if (last_en >= 0 && (k - last_en) != 4) gap_err++;
        if (first_en < 0) first_en = k;
        last_en = k;
        n_en++;
      end
      if (expire_pulse) begin
        n_exp++;
        exp_at = k;
      end
      if (err) n_err++;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    set_target(12'h000);
`ifdef BCD_TIMER_LAP_EN
    lap = 1'b0;
`endif
    load_req = 1'b0;
    load_val = '0;
    cnt_load(12'h000);
    step();
    chk("reset_outs", 32'({running, paused, expired, expire_pulse, err, cnt_en, cnt_clr}), 32'h0);
    reset_n = 1'b1;
    step();

    // Target 012 from 000
    set_target(12'h012);
    cmd_start();
    chk("t1_running", 32'(running), 1);
    watch(60);
    chk("t1_first_en", 32'(first_en), 3);
    chk("t1_gap", 32'(gap_err), 0);
    chk("t1_n_en", 32'(n_en), 12);
    chk("t1_exp_at", 32'(exp_at), 49);
    chk("t1_n_exp", 32'(n_exp), 1);
    chk("t1_count", 32'(cnt), 32'h012);
    chk("t1_expired", 32'(expired), 1);
    chk("t1_running_off", 32'(running), 0);

    // Clear from DONE, then non-BCD target
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t2_cnt_clr", 32'(cnt_clr), 1);
    chk("t2_expired_off", 32'(expired), 0);
    step();
    chk("t2_count_zero", 32'(cnt), 32'h000);
    set_target(12'h0A5);
    cmd_start();
    chk("t2_err", 32'(err), 1);
    chk("t2_idle", 32'(running), 0);
    watch(12);
    chk("t2_no_en", 32'(n_en), 0);
    chk("t2_err_once", 32'(n_err), 1);
    chk("t2_still_idle", 32'(running), 0);

    // Pause at 007 and resume
    set_target(12'h020);
    cmd_start();
    for (int k = 0; k < 100 && cnt != 12'h007; k++) step();
    chk("t3_reach_007", 32'(cnt), 32'h007);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3_paused", 32'(paused), 1);
    watch(50);
    chk("t3_no_en_paused", 32'(n_en), 0);
    chk("t3_count_held", 32'(cnt), 32'h007);
    cmd_start();
    chk("t3_resumed", 32'(running), 1);
    watch(4);
    chk("t3_resume_en", 32'(first_en), 2);
    chk("t3_count_008", 32'(cnt), 32'h008);
    cmd_clear();

    // Wrap 998 -> 001
    cnt_load(12'h998);
    set_target(12'h001);
    cmd_start();
    watch(20);
    chk("t4_n_en", 32'(n_en), 3);
    chk("t4_exp_at", 32'(exp_at), 13);
    chk("t4_count", 32'(cnt), 32'h001);
    chk("t4_expired", 32'(expired), 1);

    // Target equal to count at start
    cmd_clear();
    set_target(12'h000);
    cmd_start();
    watch(6);
    chk("t5_eq_no_en", 32'(n_en), 0);
    chk("t5_eq_exp_at", 32'(exp_at), 1);

    // Restart from DONE
    set_target(12'h002);
    cmd_start();
    chk("t6_done_clr", 32'(cnt_clr), 1);
    chk("t6_done_run", 32'(running), 1);
    watch(12);
    chk("t6_n_en", 32'(n_en), 2);
    chk("t6_exp_at", 32'(exp_at), 9);
    chk("t6_count", 32'(cnt), 32'h002);

    // clear + stop + start together during RUN
    cmd_clear();
    set_target(12'h050);
    cmd_start();
    repeat (5) step();
    clear = 1'b1; stop = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    chk("t7_cnt_clr", 32'(cnt_clr), 1);
    chk("t7_state_idle", 32'({running, paused, expired}), 0);
    chk("t7_no_err", 32'(err), 0);
    step();
    chk("t7_clr_pulse", 32'(cnt_clr), 0);

    // Asynchronous reset mid-RUN while cnt_en is high
    cmd_start();
    for (int k = 0; k < 10 && !cnt_en; k++) step();
    chk("t8_pre_rst_en", 32'(cnt_en), 1);
    reset_n = 1'b0;
    #1;
    chk("t8_async_rst", 32'({running, paused, expired, expire_pulse, err, cnt_en, cnt_clr}), 0);
    step();
    reset_n = 1'b1;
    step();

`ifdef BCD_TIMER_LAP_EN
    cnt_load(12'h000);
    set_target(12'h050);
    cmd_start();
    for (int k = 0; k < 400 && cnt != 12'h045; k++) step();
    chk("lap_reach_045", 32'(cnt), 32'h045);
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk("lap_valid", 32'(lap_valid), 1);
    chk("lap_value", 32'({lap_hundreds, lap_tens, lap_ones}), 32'h045);
    step();
    chk("lap_valid_pulse", 32'(lap_valid), 0);
    for (int k = 0; k < 100 && !expired; k++) step();
    chk("lap_done", 32'(expired), 1);
    lap = 1'b1;
    step();
    lap = 1'b0;
    chk("lap_in_done", 32'(lap_valid), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
